// File: rtl/ex_flush_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_flush_ctrl_pkg
// Shared types and constants for the commit-side exception/ertn/interrupt
// sequencer (ex_flush_ctrl).
//   - efc_state_e : controller state encoding (IDLE / FLUSH / REDIRECT)
//   - efc_event_t : one selected commit event (what to pulse, where to go)
//   - flush_cnt_init : load value of the flush down-counter
// ----------------------------------------------------------------------------
package ex_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        EFC_IDLE     = 2'd0,
        EFC_FLUSH    = 2'd1,
        EFC_REDIRECT = 2'd2
    } efc_state_e;

    localparam logic [5:0] ECODE_INT_DEFAULT = 6'h00;

    typedef struct packed {
        logic        take;     // an event is accepted this cycle
        logic        is_ex;    // exception or interrupt -> ex_commit
        logic        is_ertn;  // ertn -> ertn_commit
        logic        cancel;   // WB instruction must not retire
        logic [5:0]  ecode;
        logic [31:0] target;   // redirect PC to latch
    } efc_event_t;

    // The counter holds "FLUSH cycles still to go after this one".
    function automatic logic [2:0] flush_cnt_init(input int unsigned cycles);
        flush_cnt_init = 3'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/ex_flush_ctrl_chk.sv
// ----------------------------------------------------------------------------
// ex_flush_ctrl_chk
// Simulation-only property checker bound beside ex_flush_ctrl.
// Ports: clk/reset, ctrl_busy, the WB event inputs and the commit pulses.
//   - WB must not present an exception or ertn while the controller is busy.
//   - ex_commit and ertn_commit are mutually exclusive and never fire while busy.
// ----------------------------------------------------------------------------
module ex_flush_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic ctrl_busy,
    input logic wb_ex,
    input logic wb_ertn_flush,
    input logic ex_commit,
    input logic ertn_commit
);

    a_no_wb_event_when_busy: assert property (
        @(posedge clk) disable iff (reset)
        ctrl_busy |-> !(wb_ex || wb_ertn_flush)
    ) else $error("ex_flush_ctrl: wb_ex/wb_ertn_flush seen while controller busy");

    a_commit_exclusive: assert property (
        @(posedge clk) disable iff (reset)
        !(ex_commit && ertn_commit)
    ) else $error("ex_flush_ctrl: ex_commit and ertn_commit both high");

    a_no_commit_when_busy: assert property (
        @(posedge clk) disable iff (reset)
        ctrl_busy |-> !(ex_commit || ertn_commit)
    ) else $error("ex_flush_ctrl: commit pulse while controller busy");

endmodule

// File: rtl/ex_flush_ctrl.sv
// ----------------------------------------------------------------------------
// ex_flush_ctrl
// Commit-side sequencer next to WB. In IDLE it picks one event per cycle
// (exception > interrupt > ertn), emits the commit pulse and cancel in the same
// cycle, flushes the pipeline for 1 + FLUSH_CYCLES cycles, then holds a
// redirect request until IF accepts it.
// Parameters: FLUSH_CYCLES (1..7) FLUSH-state length, ECODE_INT interrupt ecode.
// Ports:
//   clk, reset (sync, active-high)
//   ws_commit_valid, wb_ex, wb_ertn_flush, wb_pc, wb_ecode   : WB stage
//   int_pending, csr_eentry, csr_era                          : CSR
//   fs_redirect_ready                                         : IF handshake
//   ws_cancel, ex_commit, ex_commit_ecode, ertn_commit        : commit side
//   flush_all, redirect_valid, redirect_pc, ctrl_busy         : pipeline control
// ----------------------------------------------------------------------------
import ex_flush_ctrl_pkg::*;

module ex_flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [5:0]  ECODE_INT    = ECODE_INT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_commit_valid,
    input  logic        wb_ex,
    input  logic        wb_ertn_flush,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_ecode,
    input  logic        int_pending,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        fs_redirect_ready,
    output logic        ws_cancel,
    output logic        ex_commit,
    output logic [5:0]  ex_commit_ecode,
    output logic        ertn_commit,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ctrl_busy
);

    localparam logic [2:0] FLUSH_LOAD = flush_cnt_init(FLUSH_CYCLES);

    efc_state_e state_r;
    efc_state_e state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic [31:0] redirect_pc_r;
    efc_event_t evt_s;

    // Event select: only in IDLE and never while reset is asserted.
    // ERA for an interrupt is taken from wb_pc by the CSR block, so wb_pc is
    // not needed here beyond documenting the cancelled instruction.
    always_comb begin
        evt_s = '0;
        if (state_r == EFC_IDLE && !reset) begin
            if (wb_ex) begin
                evt_s.take    = 1'b1;
                evt_s.is_ex   = 1'b1;
                evt_s.cancel  = 1'b1;
                evt_s.ecode   = wb_ecode;
                evt_s.target  = csr_eentry;
            end else if (int_pending && ws_commit_valid) begin
                evt_s.take    = 1'b1;
                evt_s.is_ex   = 1'b1;
                evt_s.cancel  = 1'b1;
                evt_s.ecode   = ECODE_INT;
                evt_s.target  = csr_eentry;
            end else if (wb_ertn_flush) begin
                evt_s.take    = 1'b1;
                evt_s.is_ertn = 1'b1;
                evt_s.target  = csr_era;
            end else begin
                evt_s = '0;
            end
        end else begin
            evt_s = '0;
        end
    end

    // State, flush counter and redirect target registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= EFC_IDLE;
            cnt_r         <= 3'd0;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (evt_s.take) begin
                redirect_pc_r <= evt_s.target;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    // Next-state and flush down-counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            EFC_IDLE: begin
                if (evt_s.take) begin
                    state_nxt_s = EFC_FLUSH;
                    cnt_nxt_s   = FLUSH_LOAD;
                end else begin
                    state_nxt_s = EFC_IDLE;
                end
            end
            EFC_FLUSH: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = EFC_REDIRECT;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            EFC_REDIRECT: begin
                if (fs_redirect_ready) begin
                    state_nxt_s = EFC_IDLE;
                end else begin
                    state_nxt_s = EFC_REDIRECT;
                end
            end
            default: begin
                state_nxt_s = EFC_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // Outputs: commit pulses are same-cycle with the event; flush covers the
    // event cycle plus every FLUSH cycle.
    always_comb begin
        ws_cancel       = evt_s.cancel;
        ex_commit       = evt_s.is_ex;
        ertn_commit     = evt_s.is_ertn;
        ex_commit_ecode = evt_s.ecode;
        flush_all       = evt_s.take || (state_r == EFC_FLUSH);
        redirect_valid  = (state_r == EFC_REDIRECT);
        redirect_pc     = redirect_pc_r;
        ctrl_busy       = (state_r != EFC_IDLE);
    end

    ex_flush_ctrl_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .ctrl_busy     (ctrl_busy),
        .wb_ex         (wb_ex),
        .wb_ertn_flush (wb_ertn_flush),
        .ex_commit     (ex_commit),
        .ertn_commit   (ertn_commit)
    );

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_flush_ctrl
// Two instances share all stimulus: u_d1 with FLUSH_CYCLES=1, u_d3 with
// FLUSH_CYCLES=3. Each directed vector carries its hand-computed expected
// commit record, pushed into a per-instance queue; a negedge monitor pops a
// record on every commit pulse and then follows flush length, redirect PC and
// redirect duration for that event.
// ----------------------------------------------------------------------------
module tb_ex_flush_ctrl;

    localparam int unsigned FC3 = 3;

    typedef struct {
        logic        ex;
        logic        ertn;
        logic        cancel;
        logic [5:0]  ecode;
        logic [31:0] pc;
        int          flush;   // expected flush_all cycles incl. event cycle
        int          redir;   // expected redirect_valid cycles, -1 = don't check
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_commit_valid, wb_ex, wb_ertn_flush, int_pending, fs_redirect_ready;
    logic [31:0] wb_pc, csr_eentry, csr_era;
    logic [5:0]  wb_ecode;

    logic        cancel_a, exc_a, ertc_a, fl_a, rv_a, busy_a;
    logic [5:0]  ec_a;
    logic [31:0] rpc_a;
    logic        cancel_b, exc_b, ertc_b, fl_b, rv_b, busy_b;
    logic [5:0]  ec_b;
    logic [31:0] rpc_b;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    int   phase[2];
    int   fcnt[2];
    int   rcnt[2];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ex_flush_ctrl #(.FLUSH_CYCLES(1)) u_d1 (
        .clk(clk), .reset(reset), .ws_commit_valid(ws_commit_valid), .wb_ex(wb_ex),
        .wb_ertn_flush(wb_ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .fs_redirect_ready(fs_redirect_ready), .ws_cancel(cancel_a), .ex_commit(exc_a),
        .ex_commit_ecode(ec_a), .ertn_commit(ertc_a), .flush_all(fl_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .ctrl_busy(busy_a)
    );

    ex_flush_ctrl #(.FLUSH_CYCLES(FC3)) u_d3 (
        .clk(clk), .reset(reset), .ws_commit_valid(ws_commit_valid), .wb_ex(wb_ex),
        .wb_ertn_flush(wb_ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .fs_redirect_ready(fs_redirect_ready), .ws_cancel(cancel_b), .ex_commit(exc_b),
        .ex_commit_ecode(ec_b), .ertn_commit(ertc_b), .flush_all(fl_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .ctrl_busy(busy_b)
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // One monitor step for instance d, sampled at negedge.
    task automatic mon_step(input int d, input logic exc, input logic ertc, input logic canc,
                            input logic [5:0] ec, input logic fl, input logic rv,
                            input logic [31:0] rpc, input logic busy);
        exp_t e;
        if (reset) begin
            phase[d] = 0;
        end else begin
            if (phase[d] == 2 && !rv) begin
                if (cur[d].redir >= 0) chk("redirect_cycles", d, rcnt[d], cur[d].redir);
                chk("idle_after_redirect", d, {31'd0, busy}, 32'd0);
                phase[d] = 0;
            end
            if (phase[d] == 0) begin
                if (exc || ertc) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("unexpected_commit", d, {30'd0, exc, ertc}, 32'd0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        cur[d] = e;
                        chk("ex_commit", d, {31'd0, exc}, {31'd0, e.ex});
                        chk("ertn_commit", d, {31'd0, ertc}, {31'd0, e.ertn});
                        chk("ws_cancel", d, {31'd0, canc}, {31'd0, e.cancel});
                        chk("ecode", d, {26'd0, ec}, {26'd0, e.ecode});
                        chk("flush_evt_cycle", d, {30'd0, fl, rv}, 32'd2);
                        chk("busy_evt_cycle", d, {31'd0, busy}, 32'd0);
                        phase[d] = 1;
                        fcnt[d]  = 1;
                    end
                end else begin
                    chk("quiet", d, {28'd0, fl, rv, busy, canc}, 32'd0);
                end
            end else if (phase[d] == 1) begin
                chk("no_pulse_busy", d, {30'd0, exc, ertc}, 32'd0);
                chk("busy_flush", d, {31'd0, busy}, 32'd1);
                if (fl) begin
                    fcnt[d]++;
                    chk("no_redir_in_flush", d, {31'd0, rv}, 32'd0);
                end else if (rv) begin
                    chk("flush_cycles", d, fcnt[d], cur[d].flush);
                    chk("redirect_pc", d, rpc, cur[d].pc);
                    phase[d] = 2;
                    rcnt[d]  = 1;
                end else begin
                    chk("flush_exit", d, {31'd0, rv}, 32'd1);
                    phase[d] = 0;
                end
            end else begin
                rcnt[d]++;
                chk("no_pulse_busy", d, {30'd0, exc, ertc}, 32'd0);
                chk("redirect_hold", d, {29'd0, fl, rv, busy}, 32'd3);
                chk("redirect_pc_stable", d, rpc, cur[d].pc);
            end
        end
    endtask

    // Monitor process: independent of stimulus, driven only by DUT outputs.
    always @(negedge clk) begin
        mon_step(0, exc_a, ertc_a, cancel_a, ec_a, fl_a, rv_a, rpc_a, busy_a);
        mon_step(1, exc_b, ertc_b, cancel_b, ec_b, fl_b, rv_b, rpc_b, busy_b);
    end

    // Drive one event cycle and push hand-computed expectations.
    task automatic fire(input logic ex, input logic ertn, input logic intp, input logic cv,
                        input logic [5:0] ec, input logic take, input logic e_ex,
                        input logic e_ertn, input logic e_cancel, input logic [5:0] e_ec,
                        input logic [31:0] e_pc, input int r1, input int r3);
        exp_t e;
        @(posedge clk); #2;
        wb_ex = ex; wb_ertn_flush = ertn; int_pending = intp; ws_commit_valid = cv;
        wb_ecode = ec;
        if (take) begin
            e.ex = e_ex; e.ertn = e_ertn; e.cancel = e_cancel; e.ecode = e_ec; e.pc = e_pc;
            e.flush = 2;           e.redir = r1; q0.push_back(e);
            e.flush = 1 + int'(FC3); e.redir = r3; q1.push_back(e);
        end
        @(posedge clk); #2;
        wb_ex = 1'b0; wb_ertn_flush = 1'b0; int_pending = 1'b0; ws_commit_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_a && !busy_b) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        chk("idle_timeout", 0, {31'd0, done}, 32'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        reset = 1'b1; ws_commit_valid = 1'b0; wb_ex = 1'b0; wb_ertn_flush = 1'b0;
        int_pending = 1'b0; fs_redirect_ready = 1'b1; wb_pc = 32'h1C00_0100;
        wb_ecode = 6'h00; csr_eentry = 32'h0000_0000; csr_era = 32'h0000_0000;
        phase[0] = 0; phase[1] = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("reset_pc", 0, rpc_a, 32'h0);
        chk("reset_pc", 1, rpc_b, 32'h0);
        csr_eentry = 32'h1C00_8000;
        csr_era    = 32'h1C00_0104;
        @(posedge clk); #2;

        // exception, ready already high
        fire(1'b1, 1'b0, 1'b0, 1'b1, 6'h0B, 1'b1, 1'b1, 1'b0, 1'b1, 6'h0B, 32'h1C00_8000, 1, 1);
        wait_idle();
        // ertn retires, goes to ERA
        fire(1'b0, 1'b1, 1'b0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 32'h1C00_0104, 1, 1);
        wait_idle();
        // interrupt on a committing instruction
        fire(1'b0, 1'b0, 1'b1, 1'b1, 6'h15, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 32'h1C00_8000, 1, 1);
        wait_idle();
        // interrupt without a committing instruction: no event
        fire(1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 0, 0);
        wait_idle();
        // all three at once: exception wins
        fire(1'b1, 1'b1, 1'b1, 1'b1, 6'h21, 1'b1, 1'b1, 1'b0, 1'b1, 6'h21, 32'h1C00_8000, 1, 1);
        wait_idle();
        // interrupt and ertn: interrupt wins
        fire(1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 32'h1C00_8000, 1, 1);
        wait_idle();

        // ready held low; redirect lasts 8 cycles (FC=1) / 6 cycles (FC=3)
        csr_eentry = 32'h1C00_A000;
        fs_redirect_ready = 1'b0;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 6'h0A, 1'b1, 1'b1, 1'b0, 1'b1, 6'h0A, 32'h1C00_A000, 8, 6);
        int_pending = 1'b1; ws_commit_valid = 1'b1;   // must be ignored while busy
        csr_eentry  = 32'h1C00_F000;                  // redirect_pc must not follow
        repeat (3) @(posedge clk);
        #2;
        int_pending = 1'b0; ws_commit_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        fs_redirect_ready = 1'b1;
        wait_idle();

        // reset while both instances sit in REDIRECT
        fs_redirect_ready = 1'b0;
        fire(1'b0, 1'b1, 1'b0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 32'h1C00_0104, -1, -1);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_redirect", 0, {31'd0, rv_a}, 32'd1);
        chk("pre_reset_redirect", 1, {31'd0, rv_b}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("post_reset_outs", 0, {27'd0, fl_a, rv_a, busy_a, exc_a, ertc_a}, 32'd0);
        chk("post_reset_outs", 1, {27'd0, fl_b, rv_b, busy_b, exc_b, ertc_b}, 32'd0);
        chk("post_reset_pc", 0, rpc_a, 32'h0);
        chk("post_reset_pc", 1, rpc_b, 32'h0);
        fs_redirect_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        chk("queue_drained", 0, q0.size(), 32'd0);
        chk("queue_drained", 1, q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
